// File: rtl/tsip_timing_decoder.sv
// TSIP byte-stream de-stuffer and Primary Timing (0x8F-AB) packet decoder.
// Define TSIP_FLAG_CHECK_EN to accept packets only when the timing flag reports valid UTC time.
module tsip_timing_decoder #(
    parameter int unsigned MAX_LEN = 64
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_rx_dv,
    input  logic [7:0]  i_rx_byte,
    output logic        o_thunder_packet_dv,
    output logic [15:0] o_thunder_year,
    output logic [7:0]  o_thunder_month,
    output logic [7:0]  o_thunder_day,
    output logic [7:0]  o_thunder_hour,
    output logic [7:0]  o_thunder_minutes,
    output logic [7:0]  o_thunder_seconds,
    output logic [7:0]  o_timing_flag,
    output logic        o_frame_err
);

    localparam int unsigned CW        = $clog2(MAX_LEN + 1);
    localparam int unsigned FIRST_CAP = 9;
    localparam int unsigned NUM_CAP   = 8;
    localparam int unsigned PKT_LEN   = 17;
    localparam logic [7:0]  DLE       = 8'h10;
    localparam logic [7:0]  ETX       = 8'h03;
    localparam logic [7:0]  ID_TIMING = 8'h8F;
    localparam logic [7:0]  SUB_TIM   = 8'hAB;

    typedef enum logic [1:0] {StIdle, StId, StData, StDleSeen} state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [7:0]    id_q, id_d;
    logic          sub_ok_q, sub_ok_d;
    // Shadow order: flag, seconds, minutes, hour, day, month, year MSB, year LSB.
    logic [7:0]    shadow_q [NUM_CAP];
    logic [7:0]    shadow_d [NUM_CAP];
    logic          dv_q, dv_d;
    logic          err_q, err_d;
    logic [15:0]   year_q, year_d;
    logic [7:0]    month_q, month_d;
    logic [7:0]    day_q, day_d;
    logic [7:0]    hour_q, hour_d;
    logic [7:0]    min_q, min_d;
    logic [7:0]    sec_q, sec_d;
    logic [7:0]    flag_q, flag_d;

    logic          store_data;
    logic          frame_end;
    logic          flag_ok;
    logic [2:0]    cap_idx;

    assign cap_idx = 3'(cnt_q - CW'(FIRST_CAP));

`ifdef TSIP_FLAG_CHECK_EN
    assign flag_ok = shadow_q[0][0] & ~shadow_q[0][2] & ~shadow_q[0][3];
`else
    assign flag_ok = 1'b1;
`endif

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        id_d       = id_q;
        sub_ok_d   = sub_ok_q;
        shadow_d   = shadow_q;
        dv_d       = 1'b0;
        err_d      = 1'b0;
        year_d     = year_q;
        month_d    = month_q;
        day_d      = day_q;
        hour_d     = hour_q;
        min_d      = min_q;
        sec_d      = sec_q;
        flag_d     = flag_q;
        store_data = 1'b0;
        frame_end  = 1'b0;

        if (i_rx_dv) begin
            unique case (state_q)
                StIdle: begin
                    if (i_rx_byte == DLE) state_d = StId;
                end
                StId: begin
                    if (i_rx_byte == DLE || i_rx_byte == ETX) begin
                        state_d = StIdle;
                    end else begin
                        id_d     = i_rx_byte;
                        cnt_d    = '0;
                        sub_ok_d = 1'b0;
                        state_d  = StData;
                    end
                end
                StData: begin
                    if (i_rx_byte == DLE) state_d = StDleSeen;
                    else                  store_data = 1'b1;
                end
                StDleSeen: begin
                    if (i_rx_byte == DLE) begin
                        store_data = 1'b1;
                    end else if (i_rx_byte == ETX) begin
                        frame_end = 1'b1;
                        state_d   = StIdle;
                    end else begin
                        // Unescaped DLE + ID: a new frame started without the old one closing.
                        err_d    = (id_q == ID_TIMING);
                        id_d     = i_rx_byte;
                        cnt_d    = '0;
                        sub_ok_d = 1'b0;
                        state_d  = StData;
                    end
                end
                default: state_d = StIdle;
            endcase
        end

        // A stuffed DLE DLE stores 0x10, which is the byte currently on the bus.
        if (store_data) begin
            if (cnt_q == CW'(MAX_LEN)) begin
                state_d = StIdle;
                err_d   = (id_q == ID_TIMING);
            end else begin
                state_d = StData;
                if (cnt_q == '0) sub_ok_d = (i_rx_byte == SUB_TIM);
                if (cnt_q >= CW'(FIRST_CAP) && cnt_q < CW'(FIRST_CAP + NUM_CAP)) begin
                    shadow_d[cap_idx] = i_rx_byte;
                end
                cnt_d = cnt_q + CW'(1);
            end
        end

        if (frame_end && id_q == ID_TIMING && sub_ok_q) begin
            if (cnt_q == CW'(PKT_LEN) && flag_ok) begin
                dv_d    = 1'b1;
                flag_d  = shadow_q[0];
                sec_d   = shadow_q[1];
                min_d   = shadow_q[2];
                hour_d  = shadow_q[3];
                day_d   = shadow_q[4];
                month_d = shadow_q[5];
                year_d  = {shadow_q[6], shadow_q[7]};
            end else begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            id_q     <= '0;
            sub_ok_q <= 1'b0;
            shadow_q <= '{default: '0};
            dv_q     <= 1'b0;
            err_q    <= 1'b0;
            year_q   <= '0;
            month_q  <= '0;
            day_q    <= '0;
            hour_q   <= '0;
            min_q    <= '0;
            sec_q    <= '0;
            flag_q   <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            id_q     <= id_d;
            sub_ok_q <= sub_ok_d;
            shadow_q <= shadow_d;
            dv_q     <= dv_d;
            err_q    <= err_d;
            year_q   <= year_d;
            month_q  <= month_d;
            day_q    <= day_d;
            hour_q   <= hour_d;
            min_q    <= min_d;
            sec_q    <= sec_d;
            flag_q   <= flag_d;
        end
    end

    assign o_thunder_packet_dv = dv_q;
    assign o_frame_err         = err_q;
    assign o_thunder_year      = year_q;
    assign o_thunder_month     = month_q;
    assign o_thunder_day       = day_q;
    assign o_thunder_hour      = hour_q;
    assign o_thunder_minutes   = min_q;
    assign o_thunder_seconds   = sec_q;
    assign o_timing_flag       = flag_q;

endmodule

// File: tb/tb_tsip_timing_decoder.sv
// Scoreboard bench for tsip_timing_decoder: frame-level reference model, decoupled monitor.
`timescale 1ns/1ps
module tb_tsip_timing_decoder;

    localparam logic [7:0] DLE = 8'h10;
    localparam logic [7:0] ETX = 8'h03;

    typedef logic [7:0] bq_t [$];
    typedef struct packed {
        logic        is_err;
        logic [63:0] f;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        rx_dv = 1'b0;
    logic [7:0]  rx_byte = 8'h00;
    logic        pkt_dv;
    logic [15:0] year;
    logic [7:0]  month, day, hour, minutes, seconds, tflag;
    logic        frame_err;

    int          n_checks = 0;
    int          n_fail = 0;
    exp_t        sb[$];
    logic [63:0] held = '0;

    tsip_timing_decoder #(.MAX_LEN(64)) dut (
        .i_clk               (clk),
        .i_rst               (rst_n),
        .i_rx_dv             (rx_dv),
        .i_rx_byte           (rx_byte),
        .o_thunder_packet_dv (pkt_dv),
        .o_thunder_year      (year),
        .o_thunder_month     (month),
        .o_thunder_day       (day),
        .o_thunder_hour      (hour),
        .o_thunder_minutes   (minutes),
        .o_thunder_seconds   (seconds),
        .o_timing_flag       (tflag),
        .o_frame_err         (frame_err)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] dut_fields();
        return {year, month, day, hour, minutes, seconds, tflag};
    endfunction

    // Reference model: what a complete frame (ID + de-stuffed payload + ETX) must produce.
    function automatic void model_frame(input logic [7:0] id, input bq_t p);
        logic [7:0] flag;
        if (id != 8'h8F || p.size() == 0) return;
        if (p[0] != 8'hAB) return;
        if (p.size() != 17) begin
            sb.push_back(exp_t'({1'b1, held}));
            return;
        end
        flag = p[9];
`ifdef TSIP_FLAG_CHECK_EN
        if (!(flag[0] && !flag[2] && !flag[3])) begin
            sb.push_back(exp_t'({1'b1, held}));
            return;
        end
`endif
        held = {p[15], p[16], p[14], p[13], p[12], p[11], p[10], flag};
        sb.push_back(exp_t'({1'b0, held}));
    endfunction

    function automatic bq_t make_timing(input logic [7:0] flag, input logic [7:0] sec,
                                        input logic [7:0] mn, input logic [7:0] hr,
                                        input logic [7:0] dy, input logic [7:0] mo,
                                        input logic [15:0] yr);
        bq_t p;
        p.push_back(8'hAB);
        repeat (8) p.push_back(8'($urandom));
        p.push_back(flag);
        p.push_back(sec);
        p.push_back(mn);
        p.push_back(hr);
        p.push_back(dy);
        p.push_back(mo);
        p.push_back(yr[15:8]);
        p.push_back(yr[7:0]);
        return p;
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_raw(input logic [7:0] b, input int maxgap);
        rx_dv   = 1'b1;
        rx_byte = b;
        tick();
        rx_dv = 1'b0;
        repeat ($urandom_range(maxgap, 0)) tick();
    endtask

    task automatic send_data(input logic [7:0] b, input int maxgap);
        send_raw(b, maxgap);
        if (b == DLE) send_raw(b, maxgap);
    endtask

    task automatic send_frame(input logic [7:0] id, input bq_t p, input int maxgap);
        model_frame(id, p);
        send_raw(DLE, maxgap);
        send_raw(id, maxgap);
        foreach (p[i]) send_data(p[i], maxgap);
        send_raw(DLE, maxgap);
        send_raw(ETX, maxgap);
    endtask

    task automatic settle(input string name);
        repeat (3) tick();
        check(name, 64'(sb.size()), 64'd0);
        sb.delete();
    endtask

    // Monitor: every strobe must match the next expected event, in order.
    always @(negedge clk) begin
        if (rst_n) begin
            if (pkt_dv && frame_err) begin
                n_checks++;
                n_fail++;
                $display("FAIL exclusive: dv and frame_err both high");
            end else if (pkt_dv || frame_err) begin
                exp_t e;
                n_checks++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected: got err=%0b fields=%h, none expected",
                             frame_err, dut_fields());
                end else begin
                    e = sb.pop_front();
                    if (e.is_err !== frame_err || e.f !== dut_fields()) begin
                        n_fail++;
                        $display("FAIL scoreboard: got err=%0b fields=%h expected err=%0b fields=%h",
                                 frame_err, dut_fields(), e.is_err, e.f);
                    end
                end
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bq_t p;
        logic [7:0] b;

        #2 rst_n = 1'b0;
        #1 check("reset_outputs", {dut_fields(), 6'b0, pkt_dv, frame_err}, '0);
        repeat (3) tick();
        rst_n = 1'b1;
        tick();

        // Nominal packet.
        send_frame(8'h8F, make_timing(8'h03, 8'd28, 8'd55, 8'd11, 8'd15, 8'd7, 16'd2020), 2);
        settle("nominal_pending");
        check("nominal_year", year, 16'd2020);
        check("nominal_time", {hour, minutes, seconds}, {8'd11, 8'd55, 8'd28});
        check("nominal_date", {month, day}, {8'd7, 8'd15});

        // Seconds = 0x10 travels stuffed, back-to-back bytes.
        send_frame(8'h8F, make_timing(8'h03, 8'd16, 8'd56, 8'd11, 8'd15, 8'd7, 16'd2020), 0);
        settle("stuff_pending");
        check("stuff_seconds", seconds, 8'd16);

        // Filtering: wrong subcode, foreign ID, then a good packet.
        p = make_timing(8'h03, 8'd40, 8'd1, 8'd2, 8'd3, 8'd4, 16'd1999);
        p[0] = 8'hAC;
        send_frame(8'h8F, p, 1);
        p.delete();
        repeat (20) p.push_back(8'($urandom));
        send_frame(8'h47, p, 1);
        settle("filter_pending");
        check("filter_unchanged", seconds, 8'd16);
        send_frame(8'h8F, make_timing(8'h03, 8'd29, 8'd56, 8'd11, 8'd15, 8'd7, 16'd2020), 1);
        settle("filter_accept_pending");
        check("filter_accept_sec", seconds, 8'd29);

        // Short packet (16 payload bytes).
        p = make_timing(8'h03, 8'd50, 8'd1, 8'd1, 8'd1, 8'd1, 16'd2001);
        void'(p.pop_back());
        send_frame(8'h8F, p, 1);
        settle("short_pending");

        // Resync: DLE + 0x8F mid-payload aborts and restarts.
        send_raw(DLE, 0);
        send_raw(8'h8F, 0);
        send_data(8'hAB, 0);
        send_data(8'h01, 0);
        send_data(8'h02, 0);
        sb.push_back(exp_t'({1'b1, held}));
        send_raw(DLE, 0);
        p = make_timing(8'h03, 8'd31, 8'd57, 8'd12, 8'd16, 8'd8, 16'd2021);
        model_frame(8'h8F, p);
        send_raw(8'h8F, 0);
        foreach (p[i]) send_data(p[i], 0);
        send_raw(DLE, 0);
        send_raw(ETX, 0);
        settle("resync_pending");

        // Overflow: 70 payload bytes without ETX; error on the 65th.
        sb.push_back(exp_t'({1'b1, held}));
        send_raw(DLE, 0);
        send_raw(8'h8F, 0);
        for (int i = 0; i < 70; i++) begin
            send_raw(8'h55, 0);
            if (i == 63) check("ovf_not_yet", 64'(sb.size()), 64'd1);
            if (i == 65) check("ovf_fired", 64'(sb.size()), 64'd0);
        end
        settle("ovf_pending");

        // Reset in the middle of byte 12 of a valid frame.
        p = make_timing(8'h03, 8'd33, 8'd0, 8'd0, 8'd1, 8'd1, 16'd2022);
        send_raw(DLE, 0);
        send_raw(8'h8F, 0);
        for (int i = 0; i < 12; i++) send_data(p[i], 0);
        rx_dv   = 1'b1;
        rx_byte = p[12];
        #1 rst_n = 1'b0;
        #1 check("midframe_reset", {dut_fields(), 6'b0, pkt_dv, frame_err}, '0);
        held = '0;
        tick();
        rx_dv = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        send_frame(8'h8F, make_timing(8'h03, 8'd30, 8'd58, 8'd13, 8'd17, 8'd9, 16'd2023), 1);
        settle("post_reset_pending");
        check("post_reset_sec", seconds, 8'd30);

        // Timing flag 0x05: gated only when the flag check is compiled in.
        send_frame(8'h8F, make_timing(8'h05, 8'd34, 8'd58, 8'd13, 8'd17, 8'd9, 16'd2023), 1);
        settle("flag_pending");
`ifdef TSIP_FLAG_CHECK_EN
        check("flag_out", tflag, 8'h03);
`else
        check("flag_out", tflag, 8'h05);
`endif

        // Randomized traffic.
        for (int n = 0; n < 150; n++) begin
            int kind;
            int len;
            logic [7:0] id;
            kind = $urandom_range(4, 0);
            p.delete();
            case (kind)
                0, 1: begin
                    p = make_timing(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
                                    8'($urandom), 8'($urandom), 16'($urandom));
                    id = 8'h8F;
                end
                2: begin
                    p = make_timing(8'h03, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 16'd6);
                    len = $urandom_range(40, 1);
                    if (len == 17) len = 18;
                    while (p.size() > len) void'(p.pop_back());
                    while (p.size() < len) p.push_back(8'($urandom));
                    id = 8'h8F;
                end
                3: begin
                    len = $urandom_range(30, 0);
                    repeat (len) p.push_back(8'($urandom));
                    if (len > 0 && p[0] == 8'hAB) p[0] = 8'hAA;
                    id = 8'h8F;
                end
                default: begin
                    len = $urandom_range(40, 0);
                    repeat (len) p.push_back(8'($urandom));
                    id = 8'($urandom);
                    if (id == DLE || id == ETX) id = 8'h47;
                end
            endcase
            send_frame(id, p, $urandom_range(2, 0));
            repeat ($urandom_range(3, 0)) begin
                b = 8'($urandom);
                if (b == DLE) b = 8'h11;
                send_raw(b, 1);
            end
            if (n % 10 == 9) settle("random_pending");
        end
        settle("final_pending");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
